// File: rtl/cpu_mul_pkg.sv
// Shared types and constants for the sequential multiply/multiply-extended unit.
package cpu_mul_pkg;

  localparam int HALF_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULXUU = 2'b01,
    MULXSU = 2'b10,
    MULXSS = 2'b11
  } mul_op_e;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    CORRECT,
    DONE
  } mul_state_e;

  // Shift tag travelling with each partial product: 0 -> <<0, 1 -> <<16, 2 -> <<32.
  function automatic logic [2*DATA_W-1:0] align_pp(input logic [DATA_W-1:0] pp,
                                                   input logic [1:0] tag);
    logic [2*DATA_W-1:0] r;
    r = '0;
    case (tag)
      2'd0:    r = {{DATA_W{1'b0}}, pp};
      2'd1:    r = {{HALF_W{1'b0}}, pp, {HALF_W{1'b0}}};
      default: r = {pp, {DATA_W{1'b0}}};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_mul_pp16.sv
// 16x16 unsigned multiplier with LATENCY register stages and a matching valid/tag pipe.
module cpu_mul_pp16
  import cpu_mul_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [1:0]        tag_i,
  input  logic [HALF_W-1:0] a_i,
  input  logic [HALF_W-1:0] b_i,
  output logic              valid_o,
  output logic [1:0]        tag_o,
  output logic [DATA_W-1:0] prod_o
);

  logic [DATA_W-1:0] prod_q  [LATENCY];
  logic [1:0]        tag_q   [LATENCY];
  logic              valid_q [LATENCY];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        prod_q[i]  <= '0;
        tag_q[i]   <= '0;
        valid_q[i] <= 1'b0;
      end
    end else begin
      prod_q[0]  <= DATA_W'(a_i) * DATA_W'(b_i);
      tag_q[0]   <= tag_i;
      valid_q[0] <= valid_i;
      for (int i = 1; i < LATENCY; i++) begin
        prod_q[i]  <= prod_q[i-1];
        tag_q[i]   <= tag_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  assign prod_o  = prod_q[LATENCY-1];
  assign tag_o   = tag_q[LATENCY-1];
  assign valid_o = valid_q[LATENCY-1];

endmodule

// File: rtl/cpu_mul_seq.sv
// Multi-cycle MUL/MULX* sequencer built on a shared 16x16 multiplier.
// Optional zero-operand shortcut enabled by defining CPU_MUL_SEQ_ZERO_BYPASS_EN.
module cpu_mul_seq
  import cpu_mul_pkg::*;
#(
  parameter int MULT_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  mul_op_e           in_op,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result
);

  localparam logic [1:0] DRAIN_LAST = 2'(MULT_LATENCY - 1);

  mul_state_e          state_q, state_d;
  mul_op_e             op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [1:0]          idx_q, idx_d;
  logic [1:0]          drain_q, drain_d;
  logic [DATA_W-1:0]   result_q, result_d;

  logic              issue_valid;
  logic [1:0]        issue_tag;
  logic [HALF_W-1:0] mul_a, mul_b;
  logic              prod_valid;
  logic [1:0]        prod_tag;
  logic [DATA_W-1:0] prod;
  logic [1:0]        last_idx;
  logic [DATA_W-1:0] hi_corr, corr;

  cpu_mul_pp16 #(.LATENCY(MULT_LATENCY)) u_pp16 (
    .clk     (clk),
    .reset   (reset),
    .valid_i (issue_valid),
    .tag_i   (issue_tag),
    .a_i     (mul_a),
    .b_i     (mul_b),
    .valid_o (prod_valid),
    .tag_o   (prod_tag),
    .prod_o  (prod)
  );

  always_comb begin
    mul_a     = a_q[HALF_W-1:0];
    mul_b     = b_q[HALF_W-1:0];
    issue_tag = 2'd0;
    case (idx_q)
      2'd1: begin mul_a = a_q[DATA_W-1:HALF_W]; issue_tag = 2'd1; end
      2'd2: begin mul_b = b_q[DATA_W-1:HALF_W]; issue_tag = 2'd1; end
      2'd3: begin
        mul_a     = a_q[DATA_W-1:HALF_W];
        mul_b     = b_q[DATA_W-1:HALF_W];
        issue_tag = 2'd2;
      end
      default: ;
    endcase
  end

  assign last_idx = (op_q == MUL) ? 2'd2 : 2'd3;

  // Two's-complement fix-up of the unsigned high word for signed operands.
  always_comb begin
    corr = '0;
    if ((op_q == MULXSU || op_q == MULXSS) && a_q[DATA_W-1]) corr = corr + b_q;
    if (op_q == MULXSS && b_q[DATA_W-1])                     corr = corr + a_q;
    hi_corr = acc_q[2*DATA_W-1:DATA_W] - corr;
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    drain_d     = drain_q;
    result_d    = result_q;
    issue_valid = 1'b0;

    if (prod_valid) acc_d = acc_q + align_pp(prod, prod_tag);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = in_op;
          a_d     = in_src1;
          b_d     = in_src2;
          acc_d   = '0;
          idx_d   = '0;
          drain_d = '0;
`ifdef CPU_MUL_SEQ_ZERO_BYPASS_EN
          if (in_src1 == '0 || in_src2 == '0) begin
            state_d  = DONE;
            result_d = '0;
          end else begin
            state_d = ISSUE;
          end
`else
          state_d = ISSUE;
`endif
        end
      end
      ISSUE: begin
        issue_valid = 1'b1;
        idx_d       = idx_q + 2'd1;
        if (idx_q == last_idx) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == DRAIN_LAST) begin
          // The final product lands this cycle, so take the low word from acc_d.
          if (op_q == MUL) begin
            state_d  = DONE;
            result_d = acc_d[DATA_W-1:0];
          end else begin
            state_d = CORRECT;
          end
        end
      end
      CORRECT: begin
        result_d = hi_corr;
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= MUL;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      drain_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      drain_q  <= drain_d;
      result_q <= result_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = result_q;

endmodule

// File: tb/tb_cpu_mul_seq.sv
// Scoreboard bench for cpu_mul_seq: result, latency, back-pressure and reset abort.
module tb_cpu_mul_seq;
  import cpu_mul_pkg::*;

  localparam int L = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  mul_op_e     in_op;
  logic [31:0] in_src1, in_src2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  cpu_mul_seq #(.MULT_LATENCY(L)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] model(input mul_op_e op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (op)
      MUL:     begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      MULXUU:  p = {32'b0, a} * {32'b0, b};
      MULXSU:  p = {{32{a[31]}}, a} * {32'b0, b};
      default: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    endcase
    return p[63:32];
  endfunction

  function automatic int model_lat(input mul_op_e op, input logic [31:0] a, input logic [31:0] b);
`ifdef CPU_MUL_SEQ_ZERO_BYPASS_EN
    if (a == 0 || b == 0) return 1;
`endif
    return (op == MUL) ? 3 + L + 1 : 4 + L + 2;
  endfunction

  // Starts and ends on a falling edge. hold>0 keeps out_ready low for that many extra cycles.
  task automatic run_op(input mul_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input bit has_spec, input logic [31:0] spec_exp, input int hold);
    int   w;
    int   n;
    exp_t e;
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    if (!in_ready) begin check_val("in_ready_timeout", in_ready, 1); return; end
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    in_op     = op;
    in_src1   = a;
    in_src2   = b;
    sb_q.push_back('{res: model(op, a, b), lat: model_lat(op, a, b)});
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 40);
    e = sb_q.pop_front();
    if (!out_valid) begin check_val("out_valid_timeout", out_valid, 1); return; end
    $display("op=%s a=0x%08h b=0x%08h result=0x%08h latency=%0d", op.name(), a, b, out_result, n);
    check_val("latency", n, e.lat);
    check_val("result", out_result, e.res);
    if (has_spec) check_val("spec_result", out_result, spec_exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val("hold_valid", out_valid, 1);
      check_val("hold_result", out_result, e.res);
      check_val("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_val("valid_drop", out_valid, 0);
    check_val("ready_back", in_ready, 1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_op     = MUL;
    in_src1   = '0;
    in_src2   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_result", out_result, 0);

    run_op(MUL,    32'h0001_0003, 32'h0002_0005, 1, 32'h000B_000F, 0);
    run_op(MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 0);
    run_op(MULXSS, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 0);
    run_op(MULXSS, 32'hFFFF_FFFF, 32'h0000_0002, 1, 32'hFFFF_FFFF, 0);
    run_op(MULXSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0);
    run_op(MUL,    32'd7,         32'd6,         1, 32'h0000_002A, 3);
    run_op(MULXSS, 32'h0000_0000, 32'h8000_0000, 1, 32'h0000_0000, 0);

    // Reset aborts an in-flight MULXUU two cycles after accept.
    in_valid = 1'b1;
    in_op    = MULXUU;
    in_src1  = 32'hFFFF_FFFF;
    in_src2  = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("abort_in_ready", in_ready, 1);
    check_val("abort_out_valid", out_valid, 0);
    run_op(MUL, 32'd3, 32'd4, 1, 32'h0000_000C, 0);

    for (int i = 0; i < 12; i++) begin
      mul_op_e     op;
      logic [31:0] a, b;
      op = mul_op_e'($urandom_range(0, 3));
      a  = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      run_op(op, a, b, 0, 32'h0, (i % 4 == 3) ? 2 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
